// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO and its RAM.
// Optional error flags are enabled with the SYNC_FIFO_ERR_FLAG_EN macro.
package sync_fifo_pkg;

  localparam int SF_DATA_WIDTH_DEF    = 8;
  localparam int SF_ADDR_WIDTH_DEF    = 4;
  localparam int SF_RAM_DEPTH_DEF     = 16;
  localparam int SF_AFULL_THRESH_DEF  = 14;
  localparam int SF_AEMPTY_THRESH_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Occupancy needs one extra bit to represent a completely full FIFO.
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The array has no reset; only the read-data register is reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy and registered status flags around
// sync_fifo_ram. Define SYNC_FIFO_ERR_FLAG_EN for sticky overflow/underflow.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = SF_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = SF_ADDR_WIDTH_DEF,
  parameter int RAM_DEPTH     = SF_RAM_DEPTH_DEF,
  parameter int AFULL_THRESH  = SF_AFULL_THRESH_DEF,
  parameter int AEMPTY_THRESH = SF_AEMPTY_THRESH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic                        rdata_valid_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        almost_full_o,
  output logic                        almost_empty_o,
`ifdef SYNC_FIFO_ERR_FLAG_EN
  input  logic                        err_clr_i,
  output logic                        overflow_o,
  output logic                        underflow_o,
`endif
  output logic [cnt_w(ADDR_WIDTH)-1:0] count_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = cnt_w(ADDR_WIDTH);

  if ((RAM_DEPTH != (1 << ADDR_WIDTH)) || (clog2(RAM_DEPTH) != ADDR_WIDTH)) begin : g_depth_chk
    $error("sync_fifo: RAM_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q, rvld_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses the flags registered before the edge, never count_d.
  assign wr_acc = wr_en_i & ~full_q;
  assign rd_acc = rd_en_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_THRESH <= 0);
      aempty_q <= 1'b1;
      rvld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(RAM_DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CW'(AFULL_THRESH));
      aempty_q <= (count_d <= CW'(AEMPTY_THRESH));
      rvld_q   <= rd_acc;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q, unf_q;

  // A new error event in the same cycle as err_clr_i keeps the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (wr_en_i & full_q)  | (ovf_q & ~err_clr_i);
      unf_q <= (rd_en_i & empty_q) | (unf_q & ~err_clr_i);
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`endif

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_o)
  );

  assign rdata_valid_o  = rvld_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;

endmodule
